// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM pattern checker: FSM states, default
// controller widths and the address-derived test pattern.
package sdram_pkg;

    localparam int DEF_ADDR_WIDTH = 23;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_GAP  = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Low nine address bits on top of the full address, so the word is
    // unique per 23-bit address; the seed keeps it away from all-zero data.
    function automatic logic [DEF_DATA_WIDTH-1:0] pattern_of(
        input logic [DEF_ADDR_WIDTH-1:0] a,
        input logic [DEF_DATA_WIDTH-1:0] seed
    );
        return seed ^ {a[8:0], a};
    endfunction

endpackage

// File: rtl/sdram_req_watchdog.sv
// Reloadable down-counter that bounds how long the checker waits on the
// controller. The reload pulse arrives one cycle after the state change it
// times, so the load value absorbs that cycle plus the owner's sampling
// edge: the owner sees o_expired on the edge TIMEOUT cycles after the change.
module sdram_req_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_reload,
    input  logic i_enable,
    output logic o_expired
);

    localparam int              CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   LOAD = CW'(TIMEOUT - 2);

    logic [CW-1:0] r_cnt;

    // Count down while the owner is waiting; restart on every reload.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= LOAD;
        end else if (i_reload) begin
            r_cnt <= LOAD;
        end else if (i_enable && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // A pending reload means the count is stale, so it cannot expire yet.
    assign o_expired = i_enable && !i_reload && (r_cnt == '0);

endmodule

// File: rtl/sdram_pattern_checker.sv
// Host-side requester for the SDRAM controller req/ack/valid port: writes
// pattern_of(addr) over [START_ADDR, LAST_ADDR], reads the range back,
// compares, and reports pass, error count, first failing address and timeout.
module sdram_pattern_checker
    import sdram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 23'h000000,
    parameter logic [ADDR_WIDTH-1:0] LAST_ADDR  = 23'h0001FF,
    parameter logic [DATA_WIDTH-1:0] SEED       = 32'hA5C3_0F96,
    parameter int                    TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           error_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  we,
    output logic                  req,
    input  logic                  ack,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] q
);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cur;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_we;
    logic                  r_req;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic                  r_timeout;
    logic [15:0]           r_err_cnt;
    logic [ADDR_WIDTH-1:0] r_first_err;
    logic                  r_wd_reload;

    logic [DATA_WIDTH-1:0] w_pat_cur;
    logic [DATA_WIDTH-1:0] w_pat_start;
    logic [ADDR_WIDTH-1:0] w_cur_inc;
    logic                  w_last;
    logic                  w_mismatch;
    logic [15:0]           w_err_next;
    logic                  w_wd_en;
    logic                  w_wd_expired;

    assign w_pat_cur   = DATA_WIDTH'(pattern_of(DEF_ADDR_WIDTH'(r_cur), DEF_DATA_WIDTH'(SEED)));
    assign w_pat_start = DATA_WIDTH'(pattern_of(DEF_ADDR_WIDTH'(START_ADDR), DEF_DATA_WIDTH'(SEED)));
    assign w_cur_inc   = r_cur + ADDR_WIDTH'(1);
    assign w_last      = (r_cur == LAST_ADDR);
    assign w_mismatch  = (q != w_pat_cur);
    assign w_err_next  = w_mismatch ? sat_inc16(r_err_cnt) : r_err_cnt;
    assign w_wd_en     = (r_state == WR_REQ) || (r_state == RD_REQ) || (r_state == RD_WAIT);

    sdram_req_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .i_clk     (clk),
        .i_rst_n   (reset_n),
        .i_reload  (r_wd_reload),
        .i_enable  (w_wd_en),
        .o_expired (w_wd_expired)
    );

    // Test sequencer: write pass, read/compare pass, result latching; all
    // controller-facing and status outputs are registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cur       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_we        <= 1'b0;
            r_req       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_wd_reload <= 1'b0;
        end else begin
            r_wd_reload <= 1'b0;
            if (w_wd_expired) begin
                // Controller stopped answering: abandon the request and report.
                r_state     <= DONE;
                r_req       <= 1'b0;
                r_we        <= 1'b0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_pass      <= 1'b0;
                r_timeout   <= 1'b1;
                r_wd_reload <= 1'b1;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (start) begin
                            r_state     <= WR_REQ;
                            r_cur       <= START_ADDR;
                            r_addr      <= START_ADDR;
                            r_data      <= w_pat_start;
                            r_we        <= 1'b1;
                            r_req       <= 1'b1;
                            r_busy      <= 1'b1;
                            r_done      <= 1'b0;
                            r_pass      <= 1'b0;
                            r_timeout   <= 1'b0;
                            r_err_cnt   <= '0;
                            r_first_err <= '0;
                            r_wd_reload <= 1'b1;
                        end
                    end
                    WR_REQ: begin
                        if (r_req && ack) begin
                            r_req       <= 1'b0;
                            r_wd_reload <= 1'b1;
                            if (w_last) begin
                                r_cur   <= START_ADDR;
                                r_we    <= 1'b0;
                                r_state <= RD_REQ;
                            end else begin
                                r_cur   <= w_cur_inc;
                                r_state <= WR_GAP;
                            end
                        end
                    end
                    WR_GAP: begin
                        // One idle cycle between requests, then the next write.
                        r_addr      <= r_cur;
                        r_data      <= w_pat_cur;
                        r_we        <= 1'b1;
                        r_req       <= 1'b1;
                        r_state     <= WR_REQ;
                        r_wd_reload <= 1'b1;
                    end
                    RD_REQ: begin
                        if (r_req && ack) begin
                            r_req       <= 1'b0;
                            r_state     <= RD_WAIT;
                            r_wd_reload <= 1'b1;
                        end else if (!r_req) begin
                            // Arrived straight from the last write ack: req was
                            // low this cycle, so it may rise now.
                            r_addr <= r_cur;
                            r_we   <= 1'b0;
                            r_req  <= 1'b1;
                        end
                    end
                    RD_WAIT: begin
                        if (valid) begin
                            r_err_cnt   <= w_err_next;
                            r_wd_reload <= 1'b1;
                            if (w_mismatch && (r_err_cnt == '0)) begin
                                r_first_err <= r_cur;
                            end
                            if (w_last) begin
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_pass  <= (w_err_next == '0) && !r_timeout;
                            end else begin
                                r_cur   <= w_cur_inc;
                                r_addr  <= w_cur_inc;
                                r_we    <= 1'b0;
                                r_req   <= 1'b1;
                                r_state <= RD_REQ;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign timeout        = r_timeout;
    assign error_count    = r_err_cnt;
    assign first_err_addr = r_first_err;
    assign addr           = r_addr;
    assign data           = r_data;
    assign we             = r_we;
    assign req            = r_req;

endmodule

// File: tb/tb_sdram_pattern_checker.sv
// Scoreboard bench for sdram_pattern_checker: instance 0 covers the default
// 0x000-0x1FF range, instance 1 the single word 0x7FFFFF. Each instance has a
// small controller model (ack 2 cycles after req, valid 3 cycles after a read ack).
module tb_sdram_pattern_checker;

    localparam int          TMO  = 4096;
    localparam logic [31:0] SEED = 32'hA5C3_0F96;

    typedef enum int {EV_WR = 0, EV_RD = 1, EV_DONE = 2} ev_t;
    typedef struct {
        ev_t         k;
        logic [22:0] a;
        logic [31:0] d;
        logic        ps;
        logic        to;
        logic [15:0] ec;
        logic [22:0] fe;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start [2];
    logic        busy [2];
    logic        done [2];
    logic        pass [2];
    logic        timeout [2];
    logic [15:0] error_count [2];
    logic [22:0] first_err_addr [2];
    logic [22:0] addr [2];
    logic [31:0] data [2];
    logic        we [2];
    logic        req [2];
    logic        ack [2];
    logic        valid [2];
    logic [31:0] q [2];
    logic        spur_v [2];

    logic corrupt;
    logic noack;
    int   cur_dut;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input logic [22:0] a);
        return SEED ^ {a[8:0], a};
    endfunction

    function automatic logic [31:0] cmask(input logic [22:0] a);
        if (!corrupt) return 32'h0;
        if (a == 23'h010) return 32'h0000_0001;
        if (a == 23'h1F0) return 32'h0001_0000;
        return 32'h0;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] req_v);
        n_cmp++;
        if (got !== req_v) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, got, req_v);
        end
    endfunction

    function automatic void push_ev(input ev_t k, input logic [22:0] a, input logic [31:0] d,
                                    input logic ps, input logic to, input logic [15:0] ec,
                                    input logic [22:0] fe);
        exp_t e;
        e.k = k; e.a = a; e.d = d; e.ps = ps; e.to = to; e.ec = ec; e.fe = fe;
        sb.push_back(e);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] m_mem [512];
        logic        m_ack;
        logic        m_valid;
        logic [31:0] m_q;
        logic [22:0] m_raddr;
        int          m_cnt;
        int          m_vdly;
        int          m_wr;

        sdram_pattern_checker #(
            .START_ADDR ((g == 0) ? 23'h000000 : 23'h7FFFFF),
            .LAST_ADDR  ((g == 0) ? 23'h0001FF : 23'h7FFFFF),
            .SEED       (SEED),
            .TIMEOUT    (TMO)
        ) u_dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .start          (start[g]),
            .busy           (busy[g]),
            .done           (done[g]),
            .pass           (pass[g]),
            .timeout        (timeout[g]),
            .error_count    (error_count[g]),
            .first_err_addr (first_err_addr[g]),
            .addr           (addr[g]),
            .data           (data[g]),
            .we             (we[g]),
            .req            (req[g]),
            .ack            (ack[g]),
            .valid          (valid[g]),
            .q              (q[g])
        );

        assign ack[g]   = m_ack;
        assign valid[g] = m_valid | spur_v[g];
        assign q[g]     = m_q;

        always @(posedge clk) begin
            if (req[g] && m_ack && we[g]) m_mem[addr[g][8:0]] <= data[g];
        end

        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                m_ack <= 1'b0; m_valid <= 1'b0; m_q <= '0; m_raddr <= '0;
                m_cnt <= 0; m_vdly <= 0; m_wr <= 0;
            end else begin
                m_valid <= 1'b0;
                if (start[g]) m_wr <= 0;
                if (req[g] && !m_ack) begin
                    if (m_cnt >= 1 && !(noack && we[g] && m_wr == 2)) begin
                        m_ack <= 1'b1;
                        m_cnt <= 0;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end else begin
                    m_ack <= 1'b0;
                    m_cnt <= 0;
                end
                if (req[g] && m_ack) begin
                    if (we[g]) m_wr <= m_wr + 1;
                    else begin
                        m_raddr <= addr[g];
                        m_vdly  <= 2;
                    end
                end
                if (m_vdly == 1) begin
                    m_valid <= 1'b1;
                    m_q     <= m_mem[m_raddr[8:0]] ^ cmask(m_raddr);
                    m_vdly  <= 0;
                end else if (m_vdly > 1) begin
                    m_vdly <= m_vdly - 1;
                end
            end
        end
    end

    // Monitor: pops one expectation per accepted request and per done rise.
    initial begin : monitor
        exp_t e;
        logic dprev [2];
        dprev[0] = 1'b0;
        dprev[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (req[cur_dut] && ack[cur_dut]) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_req: got request at %h, required none", addr[cur_dut]);
                    end else begin
                        e = sb.pop_front();
                        chk("req_kind", we[cur_dut] ? 32'd0 : 32'd1, 32'(e.k));
                        chk("req_addr", 32'(addr[cur_dut]), 32'(e.a));
                        if (e.k == EV_WR) chk("wr_data", data[cur_dut], e.d);
                    end
                end
                if (done[cur_dut] && !dprev[cur_dut]) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_done: got done=1, required no completion");
                    end else begin
                        e = sb.pop_front();
                        chk("done_kind", 32'(EV_DONE), 32'(e.k));
                        chk("pass", 32'(pass[cur_dut]), 32'(e.ps));
                        chk("timeout", 32'(timeout[cur_dut]), 32'(e.to));
                        chk("error_count", 32'(error_count[cur_dut]), 32'(e.ec));
                        chk("first_err_addr", 32'(first_err_addr[cur_dut]), 32'(e.fe));
                        chk("busy_at_done", 32'(busy[cur_dut]), 32'd0);
                        chk("req_at_done", 32'(req[cur_dut]), 32'd0);
                    end
                end
            end
            dprev[0] = done[0];
            dprev[1] = done[1];
        end
    end

    task automatic push_range(input logic ps, input logic [15:0] ec, input logic [22:0] fe);
        for (int a = 0; a <= 'h1FF; a++) push_ev(EV_WR, 23'(a), pat(23'(a)), 1'b0, 1'b0, '0, '0);
        for (int a = 0; a <= 'h1FF; a++) push_ev(EV_RD, 23'(a), '0, 1'b0, 1'b0, '0, '0);
        push_ev(EV_DONE, '0, '0, ps, 1'b0, ec, fe);
    endtask

    task automatic pulse_start(input int g);
        @(posedge clk); #1 start[g] = 1'b1;
        @(posedge clk); #1 start[g] = 1'b0;
        chk("busy_after_start", 32'(busy[g]), 32'd1);
        chk("req_after_start", 32'(req[g]), 32'd1);
    endtask

    task automatic wait_done(input int g, input int budget);
        int n = 0;
        while (!done[g] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done[g]) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_done: got done=0 after %0d cycles, required done=1", budget);
        end
    endtask

    task automatic wait_req(input int g, input logic [22:0] a, input logic w, input int budget);
        int n = 0;
        logic ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge clk);
            if (req[g] && (we[g] == w) && (addr[g] == a)) ok = 1'b1;
            n++;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_req: got no request for %h in %0d cycles, required one", a, budget);
        end
    endtask

    task automatic drain(input string nm);
        repeat (3) @(negedge clk);
        chk(nm, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic chk_zero(input int g);
        chk("rst_busy", 32'(busy[g]), 32'd0);
        chk("rst_done", 32'(done[g]), 32'd0);
        chk("rst_pass", 32'(pass[g]), 32'd0);
        chk("rst_timeout", 32'(timeout[g]), 32'd0);
        chk("rst_req", 32'(req[g]), 32'd0);
        chk("rst_we", 32'(we[g]), 32'd0);
        chk("rst_addr", 32'(addr[g]), 32'd0);
        chk("rst_data", data[g], 32'd0);
        chk("rst_error_count", 32'(error_count[g]), 32'd0);
        chk("rst_first_err_addr", 32'(first_err_addr[g]), 32'd0);
    endtask

    initial begin : stim
        int t0;
        reset_n   = 1'b0;
        start[0]  = 1'b0; start[1]  = 1'b0;
        spur_v[0] = 1'b0; spur_v[1] = 1'b0;
        corrupt   = 1'b0;
        noack     = 1'b0;
        cur_dut   = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero(0);
        chk_zero(1);
        reset_n = 1'b1;

        // Clean full range.
        push_range(1'b1, 16'd0, 23'h0);
        pulse_start(0);
        wait_done(0, 8000);
        drain("sb_empty_clean");

        // Two corrupted reads.
        corrupt = 1'b1;
        push_range(1'b0, 16'd2, 23'h010);
        pulse_start(0);
        wait_done(0, 8000);
        drain("sb_empty_corrupt");
        corrupt = 1'b0;

        // Third write never acked.
        noack = 1'b1;
        push_ev(EV_WR, 23'h0, pat(23'h0), 1'b0, 1'b0, '0, '0);
        push_ev(EV_WR, 23'h1, pat(23'h1), 1'b0, 1'b0, '0, '0);
        push_ev(EV_DONE, '0, '0, 1'b0, 1'b1, 16'd0, 23'h0);
        pulse_start(0);
        wait_req(0, 23'h2, 1'b1, 100);
        t0 = cyc;
        wait_done(0, TMO + 200);
        chk("timeout_latency", 32'(cyc - t0), 32'(TMO));
        drain("sb_empty_timeout");
        noack = 1'b0;

        // Single word at the top of the address space.
        cur_dut = 1;
        push_ev(EV_WR, 23'h7FFFFF, 32'h5A3C_F069, 1'b0, 1'b0, '0, '0);
        push_ev(EV_RD, 23'h7FFFFF, '0, 1'b0, 1'b0, '0, '0);
        push_ev(EV_DONE, '0, '0, 1'b1, 1'b0, 16'd0, 23'h0);
        pulse_start(1);
        wait_done(1, 200);
        drain("sb_empty_single");
        cur_dut = 0;

        // Reset while a read request is pending, then a clean rerun.
        push_range(1'b1, 16'd0, 23'h0);
        pulse_start(0);
        wait_req(0, 23'h5, 1'b0, 8000);
        reset_n = 1'b0;
        #1;
        chk_zero(0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        push_range(1'b1, 16'd0, 23'h0);
        pulse_start(0);
        wait_done(0, 8000);
        drain("sb_empty_rerun");

        // Start while busy and a spurious valid during a write request.
        push_range(1'b1, 16'd0, 23'h0);
        pulse_start(0);
        wait_req(0, 23'h3, 1'b1, 200);
        start[0]  = 1'b1;
        spur_v[0] = 1'b1;
        @(negedge clk);
        start[0]  = 1'b0;
        spur_v[0] = 1'b0;
        chk("busy_kept", 32'(busy[0]), 32'd1);
        wait_done(0, 8000);
        drain("sb_empty_ignore");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : global_guard
        #5000000;
        $display("FAIL global_guard: got simulation still running, required completion");
        $fatal(1, "simulation time limit");
    end

endmodule
